// File: rtl/vga_bounce_sprite.sv
// vga_bounce_sprite
//   Pixel-domain stage between the VGA timing controller and the pins.
//   Holds a square sprite that bounces inside the visible area. The sprite
//   moves once every FRAME_DIV frames. Moves only happen at frame start,
//   which is inside vertical blanking, so the picture never tears.
//   Each pixel is coloured from x/y/blank_b_in. hsync/vsync are registered
//   in the same stage as the colour, so all pin outputs stay aligned.
// Ports
//   vgaclk, reset      pixel clock, synchronous active-high reset
//   x, y               current column/row from the timing controller
//   hsync_in, vsync_in controller syncs (active-low)
//   blank_b_in         1 = visible pixel
//   pause              1 = freeze sprite position and frame counter
//   hsync, vsync       syncs delayed by one cycle
//   red, green, blue   registered pixel colour
//   box_x, box_y       sprite top-left corner
module vga_bounce_sprite #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter int          FRAME_DIV = 1,
    parameter logic [11:0] BG_COLOR  = 12'h00F,
    parameter logic [11:0] BOX_COLOR = 12'hF00
) (
    input  logic       vgaclk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       blank_b_in,
    input  logic       pause,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);

    localparam logic [10:0] MAX_X  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] MAX_Y  = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] BOX11  = 11'(BOX_SIZE);
    localparam int          CW     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);

    typedef enum logic [1:0] {S_WAIT, S_MOVE_X, S_MOVE_Y} state_t;

    // One axis of sprite motion: neg = moving toward 0.
    typedef struct packed {
        logic       neg;
        logic [9:0] pos;
    } axis_t;

    // Clamp to the edge and reverse instead of overshooting. The sum is
    // 11 bits wide so pos+STEP cannot wrap before it is compared.
    function automatic axis_t axis_step(input axis_t cur, input logic [10:0] max);
        axis_t       r;
        logic [10:0] p;
        p = {1'b0, cur.pos};
        r = cur;
        if (!cur.neg) begin
            if (p + STEP11 >= max) begin
                r.pos = max[9:0];
                r.neg = 1'b1;
            end else begin
                r.pos = 10'(p + STEP11);
            end
        end else begin
            if (p <= STEP11) begin
                r.pos = 10'd0;
                r.neg = 1'b0;
            end else begin
                r.pos = 10'(p - STEP11);
            end
        end
        return r;
    endfunction

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          vs_prev;
    logic          dir_x, dir_y;
    logic          frame_start;
    axis_t         ax_n, ay_n;
    logic          in_box;
    logic [11:0]   rgb_n;

    assign frame_start = vs_prev & ~vsync_in;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ax_n    = axis_step('{neg: dir_x, pos: box_x}, MAX_X);
        ay_n    = axis_step('{neg: dir_y, pos: box_y}, MAX_Y);
        case (state)
            S_WAIT: begin
                if (frame_start && !pause) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        state_n = S_MOVE_X;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            S_MOVE_X: state_n = S_MOVE_Y;
            S_MOVE_Y: state_n = S_WAIT;
            default:  state_n = S_WAIT;
        endcase
    end

    // Pixel colour. Bounds are compared in 11 bits so box_x+BOX_SIZE
    // cannot wrap near the right or bottom edge.
    always_comb begin
        in_box = ({1'b0, x} >= {1'b0, box_x}) && ({1'b0, x} < {1'b0, box_x} + BOX11) &&
                 ({1'b0, y} >= {1'b0, box_y}) && ({1'b0, y} < {1'b0, box_y} + BOX11);
        if (!blank_b_in)
            rgb_n = 12'h000;
        else if (in_box)
            rgb_n = BOX_COLOR;
        else
            rgb_n = BG_COLOR;
    end

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            state                <= S_WAIT;
            cnt                  <= '0;
            vs_prev              <= 1'b1;
            box_x                <= '0;
            box_y                <= '0;
            dir_x                <= 1'b0;
            dir_y                <= 1'b0;
            hsync                <= 1'b1;
            vsync                <= 1'b1;
            {red, green, blue}   <= 12'h000;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            vs_prev <= vsync_in;
            if (state == S_MOVE_X) begin
                box_x <= ax_n.pos;
                dir_x <= ax_n.neg;
            end
            if (state == S_MOVE_Y) begin
                box_y <= ay_n.pos;
                dir_y <= ay_n.neg;
            end
            hsync              <= hsync_in;
            vsync              <= vsync_in;
            {red, green, blue} <= rgb_n;
        end
    end

endmodule

// File: tb/tb_vga_bounce_sprite.sv
// Scoreboard bench for vga_bounce_sprite. It uses a small screen geometry
// so the sprite bounces off every edge many times in a short run. With
// STEP=3 the sprite reaches edges that are not multiples of STEP, which
// exercises the clamp path.
module tb_vga_bounce_sprite;

    localparam int          H    = 40;
    localparam int          V    = 30;
    localparam int          BOX  = 8;
    localparam int          STP  = 3;
    localparam int          FD   = 3;
    localparam logic [11:0] BGC  = 12'h00F;
    localparam logic [11:0] BXC  = 12'hF00;
    localparam int          NF   = 400;
    localparam int          FLEN = 16;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic [9:0]  bx;
        logic [9:0]  by;
    } exp_t;

    logic       vgaclk = 1'b0;
    logic       reset;
    logic [9:0] x, y;
    logic       hsync_in, vsync_in, blank_b_in, pause;
    logic       hsync, vsync;
    logic [3:0] red, green, blue;
    logic [9:0] box_x, box_y;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t q[$];

    always #5 vgaclk = ~vgaclk;

    vga_bounce_sprite #(
        .H_ACTIVE(H), .V_ACTIVE(V), .BOX_SIZE(BOX), .STEP(STP),
        .FRAME_DIV(FD), .BG_COLOR(BGC), .BOX_COLOR(BXC)
    ) dut (
        .vgaclk(vgaclk), .reset(reset), .x(x), .y(y),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_b_in(blank_b_in),
        .pause(pause), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .box_x(box_x), .box_y(box_y)
    );

    // Reference model. It tracks where the sprite is, which way it is
    // heading, and how many frames remain until the next move. When a move
    // is due, the model computes the new corner at once. It then lets the
    // new x corner become visible one cycle after the frame-start edge,
    // and the new y corner one cycle after that.
    int mx, my, mcnt, pendx, pendy, nx, ny;
    bit mnx, mny, mvsp, nnx, nny;

    task automatic ref_axis(input int pos, input bit neg, input int maxv,
                            output int npos, output bit nneg);
        npos = pos;
        nneg = neg;
        if (!neg) begin
            if (pos + STP >= maxv) begin npos = maxv; nneg = 1; end
            else npos = pos + STP;
        end else begin
            if (pos <= STP) begin npos = 0; nneg = 0; end
            else npos = pos - STP;
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mnx = 0; mny = 0; mcnt = 0; mvsp = 1;
        pendx = 0; pendy = 0; nx = 0; ny = 0; nnx = 0; nny = 0;
    endtask

    task automatic model_step(output exp_t e);
        bit busy;
        if (reset) begin
            model_reset();
            e = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000, bx: 10'd0, by: 10'd0};
            return;
        end
        e.hs = hsync_in;
        e.vs = vsync_in;
        if (!blank_b_in)
            e.rgb = 12'h000;
        else if (int'(x) >= mx && int'(x) < mx + BOX && int'(y) >= my && int'(y) < my + BOX)
            e.rgb = BXC;
        else
            e.rgb = BGC;
        busy = (pendx > 0) || (pendy > 0);
        if (pendx > 0) begin
            pendx--;
            if (pendx == 0) begin mx = nx; mnx = nnx; end
        end
        if (pendy > 0) begin
            pendy--;
            if (pendy == 0) begin my = ny; mny = nny; end
        end
        if (!busy && mvsp && !vsync_in && !pause) begin
            if (mcnt == FD - 1) begin
                mcnt = 0;
                ref_axis(mx, mnx, H - BOX, nx, nnx);
                ref_axis(my, mny, V - BOX, ny, nny);
                pendx = 1;
                pendy = 2;
            end else begin
                mcnt++;
            end
        end
        mvsp = vsync_in;
        e.bx = 10'(mx);
        e.by = 10'(my);
    endtask

    task automatic drive(input bit rst, input bit vs, input bit hs, input int xx,
                         input int yy, input bit bl, input bit ps);
        exp_t e;
        @(negedge vgaclk);
        reset      = rst;
        vsync_in   = vs;
        hsync_in   = hs;
        x          = 10'(xx);
        y          = 10'(yy);
        blank_b_in = bl;
        pause      = ps;
        model_step(e);
        q.push_back(e);
    endtask

    // Monitor: every output update is compared against the oldest
    // expectation.
    always @(posedge vgaclk) begin
        exp_t e, a;
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{hs: hsync, vs: vsync, rgb: {red, green, blue}, bx: box_x, by: box_y};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got hs=%b vs=%b rgb=%h box=(%0d,%0d) expected hs=%b vs=%b rgb=%h box=(%0d,%0d)",
                         cyc, a.hs, a.vs, a.rgb, a.bx, a.by, e.hs, e.vs, e.rgb, e.bx, e.by);
            end
        end
    end

    initial begin
        bit fpause;
        bit rst;
        reset = 1; x = 0; y = 0; hsync_in = 1; vsync_in = 1; blank_b_in = 1; pause = 0;
        model_reset();
        drive(1, 1, 1, 0, 0, 1, 0);
        drive(1, 1, 1, 0, 0, 1, 0);
        // Directed checks. The sprite starts at (0,0): this pixel is inside
        // the box, the next is in background, then blanked, then the syncs
        // toggle.
        drive(0, 1, 1, 0, 0, 1, 0);
        drive(0, 1, 1, 20, 0, 1, 0);
        drive(0, 1, 1, 5, 5, 0, 0);
        drive(0, 1, 0, 5, 5, 1, 0);
        drive(0, 1, 1, 7, 7, 1, 0);
        drive(0, 1, 1, 8, 7, 1, 0);

        for (int f = 0; f < NF; f++) begin
            fpause = ($urandom_range(0, 3) == 0);
            if (f >= 300 && f < 305) fpause = 1;   // long pause: must freeze
            for (int c = 0; c < FLEN; c++) begin
                // Reset one cycle after a frame start, while a move may be in flight.
                rst = ((f % 37 == 36) && c == 3) || ($urandom_range(0, 999) == 0);
                drive(rst,
                      !(c >= 2 && c < 6),
                      $urandom_range(0, 1) != 0,
                      $urandom_range(0, H + 10),
                      $urandom_range(0, V + 10),
                      $urandom_range(0, 3) != 0,
                      (c == 3 && $urandom_range(0, 1) == 0) ? 1'b1 : fpause);
            end
        end

        repeat (3) @(posedge vgaclk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
